// File: rtl/chan_mux_seq.sv
// Channel multiplexer with a select request/acknowledge handshake, a settle window and a registered valid/ready output.
// Optional feature: define CHAN_MUX_DROPCNT_EN to add a saturating drop counter (drop_cnt, drop_clr).
module chan_mux_seq #(
  parameter int WIDTH  = 12,
  parameter int NCH    = 4,
  parameter int SELW   = 2,
  parameter int SETTLE = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  input  logic [SELW-1:0]      sel_req,
  input  logic                 sel_req_vld,
  output logic                 sel_req_rdy,
  output logic [SELW-1:0]      sel_cur,
  output logic                 sel_err,
  output logic                 busy,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef CHAN_MUX_DROPCNT_EN
  ,
  input  logic                 drop_clr,
  output logic [15:0]          drop_cnt
`endif
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
  // One extra bit so the range check stays meaningful when NCH is a power of two.
  localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

  typedef enum logic {S_ACTIVE, S_SETTLE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [SELW-1:0] sel_nxt;
  logic            err_nxt;
  logic            req_bad, req_same;
  logic [WIDTH-1:0] sel_data;
  logic            sel_valid;
  logic            active, load;

  assign req_bad  = {1'b0, sel_req} >= NCH_W;
  assign req_same = (sel_req == sel_cur);
  assign active   = (state == S_ACTIVE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    sel_nxt     = sel_cur;
    err_nxt     = 1'b0;
    sel_req_rdy = 1'b0;
    busy        = 1'b0;
    case (state)
      S_ACTIVE: begin
        sel_req_rdy = 1'b1;
        if (sel_req_vld) begin
          if (req_bad) begin
            err_nxt = 1'b1;
          end else if (!req_same) begin
            sel_nxt = sel_req;
            if (SETTLE > 0) begin
              cnt_nxt   = CNT_INIT;
              state_nxt = S_SETTLE;
            end
          end
        end
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = S_ACTIVE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = S_ACTIVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_ACTIVE;
      cnt     <= '0;
      sel_cur <= '0;
      sel_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sel_cur <= sel_nxt;
      sel_err <= err_nxt;
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (sel_cur == SELW'(k)) begin
        sel_data  = in_data[k*WIDTH +: WIDTH];
        sel_valid = in_valid[k];
      end
    end
  end

  // Capture still uses the old sel_cur in the acceptance cycle; settle ignores all inputs.
  assign load = active && sel_valid && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= sel_data;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef CHAN_MUX_DROPCNT_EN
  logic drop;
  assign drop = active && sel_valid && out_valid && !out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          drop_cnt <= '0;
    else if (drop_clr)                   drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_chan_mux_seq.sv
// Directed self-checking bench for chan_mux_seq: a 4-channel instance with settle
// and a 3-channel instance without settle (to reach the out-of-range select path).
module tb_chan_mux_seq;
  logic        clk = 1'b0;
  logic        rst_n;

  logic [47:0] in_data;
  logic [3:0]  in_valid;
  logic [1:0]  sel_req;
  logic        sel_req_vld;
  logic        sel_req_rdy;
  logic [1:0]  sel_cur;
  logic        sel_err;
  logic        busy;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_ready;

  logic [35:0] in_data1;
  logic [2:0]  in_valid1;
  logic [1:0]  sel_req1;
  logic        sel_req_vld1;
  logic        sel_req_rdy1;
  logic [1:0]  sel_cur1;
  logic        sel_err1;
  logic        busy1;
  logic [11:0] out_data1;
  logic        out_valid1;
  logic        out_ready1;

`ifdef CHAN_MUX_DROPCNT_EN
  logic        drop_clr, drop_clr1;
  logic [15:0] drop_cnt, drop_cnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  chan_mux_seq #(.WIDTH(12), .NCH(4), .SELW(2), .SETTLE(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .sel_req(sel_req), .sel_req_vld(sel_req_vld), .sel_req_rdy(sel_req_rdy),
    .sel_cur(sel_cur), .sel_err(sel_err), .busy(busy),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef CHAN_MUX_DROPCNT_EN
    , .drop_clr(drop_clr), .drop_cnt(drop_cnt)
`endif
  );

  chan_mux_seq #(.WIDTH(12), .NCH(3), .SELW(2), .SETTLE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .sel_req(sel_req1), .sel_req_vld(sel_req_vld1), .sel_req_rdy(sel_req_rdy1),
    .sel_cur(sel_cur1), .sel_err(sel_err1), .busy(busy1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1)
`ifdef CHAN_MUX_DROPCNT_EN
    , .drop_clr(drop_clr1), .drop_cnt(drop_cnt1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++; if (sel_cur !== 2'd0)      begin n_fail++; $display("FAIL reset_sel_cur got %0d exp 0", sel_cur); end
    n_checks++; if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (out_data !== 12'h000)  begin n_fail++; $display("FAIL reset_out_data got %h exp 000", out_data); end
    n_checks++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (sel_err !== 1'b0)      begin n_fail++; $display("FAIL reset_sel_err got %b exp 0", sel_err); end
    n_checks++; if (sel_req_rdy !== 1'b1)  begin n_fail++; $display("FAIL reset_rdy got %b exp 1", sel_req_rdy); end
`ifdef CHAN_MUX_DROPCNT_EN
    n_checks++; if (drop_cnt !== 16'd0)    begin n_fail++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
`endif
  endtask

  task automatic test_basic();
    in_data[0 +: 12] = 12'h0A5;
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    tick();
    in_valid = 4'b0000;
    n_checks++; if (out_valid !== 1'b1)   begin n_fail++; $display("FAIL basic_valid got %b exp 1", out_valid); end
    n_checks++; if (out_data !== 12'h0A5) begin n_fail++; $display("FAIL basic_data got %h exp 0a5", out_data); end
    n_checks++; if (sel_cur !== 2'd0)     begin n_fail++; $display("FAIL basic_sel got %0d exp 0", sel_cur); end
    tick();
    n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL basic_pop got %b exp 0", out_valid); end
  endtask

  task automatic test_select_settle();
    in_data[24 +: 12] = 12'h2C2;
    in_valid    = 4'b0100;
    sel_req     = 2'd2;
    sel_req_vld = 1'b1;
    #1;
    n_checks++; if (sel_req_rdy !== 1'b1) begin n_fail++; $display("FAIL settle_accept_rdy got %b exp 1", sel_req_rdy); end
    tick();
    sel_req_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (busy !== 1'b1)        begin n_fail++; $display("FAIL settle_busy[%0d] got %b exp 1", i, busy); end
      n_checks++; if (sel_req_rdy !== 1'b0) begin n_fail++; $display("FAIL settle_rdy[%0d] got %b exp 0", i, sel_req_rdy); end
      n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL settle_ignore[%0d] got %b exp 0", i, out_valid); end
      n_checks++; if (sel_cur !== 2'd2)     begin n_fail++; $display("FAIL settle_sel[%0d] got %0d exp 2", i, sel_cur); end
      tick();
    end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL settle_busy_end got %b exp 0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL settle_first_active got %b exp 0", out_valid); end
    tick();
    in_valid = 4'b0000;
    n_checks++; if (out_valid !== 1'b1)   begin n_fail++; $display("FAIL settle_ch2_valid got %b exp 1", out_valid); end
    n_checks++; if (out_data !== 12'h2C2) begin n_fail++; $display("FAIL settle_ch2_data got %h exp 2c2", out_data); end
    tick();
  endtask

  task automatic test_bad_sel();
    out_ready1   = 1'b1;
    sel_req1     = 2'd3;
    sel_req_vld1 = 1'b1;
    tick();
    sel_req_vld1 = 1'b0;
    n_checks++; if (sel_err1 !== 1'b1) begin n_fail++; $display("FAIL badsel_err got %b exp 1", sel_err1); end
    n_checks++; if (sel_cur1 !== 2'd0) begin n_fail++; $display("FAIL badsel_sel got %0d exp 0", sel_cur1); end
    n_checks++; if (busy1 !== 1'b0)    begin n_fail++; $display("FAIL badsel_busy got %b exp 0", busy1); end
    tick();
    n_checks++; if (sel_err1 !== 1'b0) begin n_fail++; $display("FAIL badsel_pulse got %b exp 0", sel_err1); end
    // No-settle change: acceptance cycle captures from the old channel, next cycle from the new one.
    in_data1[0 +: 12]  = 12'h111;
    in_data1[24 +: 12] = 12'h222;
    in_valid1    = 3'b101;
    sel_req1     = 2'd2;
    sel_req_vld1 = 1'b1;
    tick();
    sel_req_vld1 = 1'b0;
    n_checks++; if (out_data1 !== 12'h111) begin n_fail++; $display("FAIL nosettle_old_ch got %h exp 111", out_data1); end
    n_checks++; if (sel_cur1 !== 2'd2)     begin n_fail++; $display("FAIL nosettle_sel got %0d exp 2", sel_cur1); end
    n_checks++; if (busy1 !== 1'b0)        begin n_fail++; $display("FAIL nosettle_busy got %b exp 0", busy1); end
    tick();
    in_valid1 = 3'b000;
    n_checks++; if (out_data1 !== 12'h222) begin n_fail++; $display("FAIL nosettle_new_ch got %h exp 222", out_data1); end
    tick();
  endtask

  task automatic test_drop();
    sel_req     = 2'd0;
    sel_req_vld = 1'b1;
    tick();
    sel_req_vld = 1'b0;
    repeat (3) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data[0 +: 12] = 12'h100 + 12'(i);
      in_valid = 4'b0001;
      tick();
    end
    in_valid = 4'b0000;
    n_checks++; if (out_valid !== 1'b1)   begin n_fail++; $display("FAIL drop_valid got %b exp 1", out_valid); end
    n_checks++; if (out_data !== 12'h100) begin n_fail++; $display("FAIL drop_hold got %h exp 100", out_data); end
`ifdef CHAN_MUX_DROPCNT_EN
    n_checks++; if (drop_cnt !== 16'd3)   begin n_fail++; $display("FAIL drop_cnt got %0d exp 3", drop_cnt); end
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    n_checks++; if (drop_cnt !== 16'd0)   begin n_fail++; $display("FAIL drop_clr got %0d exp 0", drop_cnt); end
`endif
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL drop_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    sel_req     = 2'd1;
    sel_req_vld = 1'b1;
    tick();
    sel_req_vld = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data[12 +: 12] = 12'h200 + 12'(i);
      in_valid = 4'b0010;
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %b exp 1", i, out_valid); end
      n_checks++; if (out_data !== 12'h200 + 12'(i)) begin n_fail++; $display("FAIL stream_data[%0d] got %h exp %h", i, out_data, 12'h200 + 12'(i)); end
    end
    in_valid = 4'b0000;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    in_data[12 +: 12] = 12'h3AB;
    in_valid    = 4'b0010;
    out_ready   = 1'b0;
    sel_req     = 2'd3;
    sel_req_vld = 1'b1;
    tick();
    sel_req_vld = 1'b0;
    in_valid    = 4'b0000;
    n_checks++; if (busy !== 1'b1)        begin n_fail++; $display("FAIL rstmid_pre_busy got %b exp 1", busy); end
    n_checks++; if (out_valid !== 1'b1)   begin n_fail++; $display("FAIL rstmid_pre_valid got %b exp 1", out_valid); end
    n_checks++; if (out_data !== 12'h3AB) begin n_fail++; $display("FAIL rstmid_pre_data got %h exp 3ab", out_data); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL rstmid_valid got %b exp 0", out_valid); end
    n_checks++; if (sel_cur !== 2'd0)    begin n_fail++; $display("FAIL rstmid_sel got %0d exp 0", sel_cur); end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (sel_req_rdy !== 1'b1) begin n_fail++; $display("FAIL rstmid_rdy got %b exp 1", sel_req_rdy); end
    n_checks++; if (out_data !== 12'h000) begin n_fail++; $display("FAIL rstmid_data got %h exp 000", out_data); end
  endtask

  initial begin
    rst_n        = 1'b0;
    in_data      = '0;
    in_valid     = '0;
    sel_req      = '0;
    sel_req_vld  = 1'b0;
    out_ready    = 1'b0;
    in_data1     = '0;
    in_valid1    = '0;
    sel_req1     = '0;
    sel_req_vld1 = 1'b0;
    out_ready1   = 1'b0;
`ifdef CHAN_MUX_DROPCNT_EN
    drop_clr     = 1'b0;
    drop_clr1    = 1'b0;
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_select_settle();
    test_bad_sel();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
